// File: rtl/matrix_read_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : matrix_read_arbiter_pkg
// Brief    : Shared types and constants for the matrix storage read arbiter
//            and other storage clients.
// Revision : 1.0 - initial release
//==============================================================================
package matrix_read_arbiter_pkg;

   // Arbiter transaction states; the encoding is fixed for debug visibility
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Storage read watchdog limit shared by every storage client
   localparam int c_TIMEOUT_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/matrix_read_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : matrix_read_arbiter_if
// Brief    : Matrix storage read port bundle. The arbiter drives the request
//            side (master); the storage block answers (slave).
// Revision : 1.0 - initial release
//==============================================================================
interface matrix_read_arbiter_if #(
   parameter int IDX_W  = 4,
   parameter int DIM_W  = 4,
   parameter int DATA_W = 200
);
   logic [IDX_W-1:0]  read_idx;
   logic              read_en;
   logic              read_done;
   logic              read_valid;
   logic [DIM_W-1:0]  read_m;
   logic [DIM_W-1:0]  read_n;
   logic [DATA_W-1:0] read_data;

   modport master (
      output read_idx, read_en,
      input  read_done, read_valid, read_m, read_n, read_data
   );

   modport slave (
      input  read_idx, read_en,
      output read_done, read_valid, read_m, read_n, read_data
   );
endinterface
`default_nettype wire

// File: rtl/matrix_read_arbiter_rr_pick.sv
`default_nettype none
//==============================================================================
// Module   : matrix_read_arbiter_rr_pick
// Brief    : Combinational round-robin picker. Returns the first set request
//            bit at or above ptr, wrapping around; found is low when no bit
//            is set. ptr must be below NUM_REQ.
// Revision : 1.0 - initial release
//==============================================================================
module matrix_read_arbiter_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               found
);

   logic [PTR_W:0] w_pos;

   // Scan offsets from farthest to nearest so the nearest set bit wins last
   always_comb begin
      winner = '0;
      found  = 1'b0;
      w_pos  = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_pos = {1'b0, ptr} + (PTR_W + 1)'(off);
         if (w_pos >= (PTR_W + 1)'(NUM_REQ)) begin
            w_pos = w_pos - (PTR_W + 1)'(NUM_REQ);
         end
         if (req[w_pos[PTR_W-1:0]]) begin
            winner = w_pos[PTR_W-1:0];
            found  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/matrix_read_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : matrix_read_arbiter
// Brief    : Round-robin sharing of the single matrix storage read port among
//            NUM_REQ requesters, one outstanding read at a time, with a
//            watchdog that aborts reads the storage never completes.
// Revision : 1.0 - initial release
//==============================================================================
module matrix_read_arbiter
   import matrix_read_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 4,
   parameter int DIM_W   = 4,
   parameter int DATA_W  = 200,
   parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx_flat,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic                     rsp_ok,
   output logic [DIM_W-1:0]         rsp_m,
   output logic [DIM_W-1:0]         rsp_n,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     busy,
   output logic                     err_timeout,
   matrix_read_arbiter_if.master    st
);

   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TIMER_W = $clog2(TIMEOUT + 1);

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   logic [PTR_W-1:0]    r_ptr;
   logic [TIMER_W-1:0]  r_timer;
   logic [PTR_W-1:0]    w_winner;
   logic                w_found;
   logic                w_take;
   logic                w_latch_done;
   logic                w_abort;
   logic [IDX_W-1:0]    w_sel_idx;
   logic [PTR_W-1:0]    w_ptr_next;

   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic                r_rsp_ok;
   logic [DIM_W-1:0]    r_rsp_m;
   logic [DIM_W-1:0]    r_rsp_n;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_busy;
   logic                r_err_timeout;
   logic [IDX_W-1:0]    r_read_idx;
   logic                r_read_en;

   matrix_read_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req     (req),
      .ptr     (r_ptr),
      .winner  (w_winner),
      .found   (w_found)
   );

   assign w_sel_idx  = IDX_W'(req_idx_flat >> (w_winner * IDX_W));
   assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; done beats the watchdog when both land together
   always_comb begin
      w_next_state = r_state;
      w_take       = 1'b0;
      w_latch_done = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_take       = 1'b1;
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (st.read_done) begin
               w_latch_done = 1'b1;
               w_next_state = ST_RESP;
            end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
               w_abort      = 1'b1;
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Registered outputs, arbitration pointer, watchdog timer and result latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr         <= '0;
         r_timer       <= '0;
         r_grant       <= '0;
         r_rsp_valid   <= '0;
         r_rsp_ok      <= 1'b0;
         r_rsp_m       <= '0;
         r_rsp_n       <= '0;
         r_rsp_data    <= '0;
         r_busy        <= 1'b0;
         r_err_timeout <= 1'b0;
         r_read_idx    <= '0;
         r_read_en     <= 1'b0;
      end else begin
         r_read_en     <= w_take;
         r_err_timeout <= w_abort;
         r_busy        <= (w_next_state != ST_IDLE);
         r_rsp_valid   <= (w_latch_done || w_abort) ? r_grant : '0;

         if (w_take) begin
            r_grant    <= NUM_REQ'(1) << w_winner;
            r_read_idx <= w_sel_idx;
            r_ptr      <= w_ptr_next;
         end
         if (r_state == ST_RESP) begin
            r_grant <= '0;
         end

         if (r_state == ST_ISSUE) begin
            r_timer <= '0;
         end else if (r_state == ST_WAIT && !st.read_done) begin
            r_timer <= r_timer + 1'b1;
         end

         if (w_latch_done) begin
            r_rsp_ok   <= st.read_valid;
            r_rsp_m    <= st.read_m;
            r_rsp_n    <= st.read_n;
            r_rsp_data <= st.read_data;
         end else if (w_abort) begin
            r_rsp_ok   <= 1'b0;
            r_rsp_m    <= '0;
            r_rsp_n    <= '0;
            r_rsp_data <= '0;
         end
      end
   end

   assign grant       = r_grant;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_ok      = r_rsp_ok;
   assign rsp_m       = r_rsp_m;
   assign rsp_n       = r_rsp_n;
   assign rsp_data    = r_rsp_data;
   assign busy        = r_busy;
   assign err_timeout = r_err_timeout;
   assign st.read_idx = r_read_idx;
   assign st.read_en  = r_read_en;

endmodule
`default_nettype wire

// File: tb/tb_matrix_read_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_matrix_read_arbiter
// Brief    : Self-checking bench for matrix_read_arbiter. A storage model
//            answers reads with random latency; a transaction-level model
//            predicts the winner, the response timing and the response data.
// Revision : 1.1 - direct comparisons at each check site
//==============================================================================
module tb_matrix_read_arbiter;

    localparam int NUM_REQ = 3;
    localparam int IDX_W   = 4;
    localparam int DIM_W   = 4;
    localparam int DATA_W  = 200;
    localparam int TIMEOUT = 15;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*IDX_W-1:0] req_idx_flat;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_ok;
    logic [DIM_W-1:0]         rsp_m;
    logic [DIM_W-1:0]         rsp_n;
    logic [DATA_W-1:0]        rsp_data;
    logic                     busy;
    logic                     err_timeout;

    matrix_read_arbiter_if #(.IDX_W(IDX_W), .DIM_W(DIM_W), .DATA_W(DATA_W)) st_if ();

    matrix_read_arbiter #(
        .NUM_REQ (NUM_REQ), .IDX_W (IDX_W), .DIM_W (DIM_W),
        .DATA_W  (DATA_W),  .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_idx_flat (req_idx_flat),
        .grant        (grant),
        .rsp_valid    (rsp_valid),
        .rsp_ok       (rsp_ok),
        .rsp_m        (rsp_m),
        .rsp_n        (rsp_n),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .st           (st_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Storage contents
    logic              mem_valid [16];
    logic [DIM_W-1:0]  mem_m     [16];
    logic [DIM_W-1:0]  mem_n     [16];
    logic [DATA_W-1:0] mem_data  [16];

    // Reference model state: rotating priority and the held response
    int                model_ptr;
    logic              exp_ok;
    logic [DIM_W-1:0]  exp_m;
    logic [DIM_W-1:0]  exp_n;
    logic [DATA_W-1:0] exp_data;

    task automatic chk(input string tag, input bit pass,
                       input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        if (!pass) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < 7; i++) d = (d << 32) | DATA_W'($urandom);
        return d;
    endfunction

    function automatic logic [IDX_W-1:0] get_idx(input int who);
        return IDX_W'(req_idx_flat >> (who * IDX_W));
    endfunction

    task automatic set_idx(input int who, input logic [IDX_W-1:0] v);
        logic [NUM_REQ*IDX_W-1:0] mask;
        mask = (NUM_REQ*IDX_W)'({IDX_W{1'b1}}) << (who * IDX_W);
        req_idx_flat = (req_idx_flat & ~mask) | ((NUM_REQ*IDX_W)'(v) << (who * IDX_W));
    endtask

    // First requester at or after the rotating pointer, wrapping; -1 if none
    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
        int pos;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = (model_ptr + off) % NUM_REQ;
            if (((r >> pos) & NUM_REQ'(1)) != 0) return pos;
        end
        return -1;
    endfunction

    // One complete transaction. respond=0 lets the watchdog fire; otherwise the
    // storage asserts done 'delay' cycles after the read_en cycle. At the
    // response cycle req is replaced by next_req (new bits get random indices).
    task automatic txn(input int delay, input bit respond, input logic [NUM_REQ-1:0] next_req);
        int w;
        int n;
        logic [IDX_W-1:0]   idx;
        logic [NUM_REQ-1:0] oh;
        logic               exp_err;
        w = model_pick(req);
        if (w < 0) begin
            chk("txn_has_request", 1'b0, '0, 1);
            return;
        end
        idx = get_idx(w);
        oh = NUM_REQ'(1) << w;
        model_ptr = (w + 1) % NUM_REQ;
        n = 0;
        while (!st_if.read_en && n < 12) begin
            tick();
            n++;
        end
        chk("read_en_seen", st_if.read_en === 1'b1, st_if.read_en, 1);
        if (!st_if.read_en) return;
        chk("grant", grant === oh, grant, oh);
        chk("read_idx", st_if.read_idx === idx, st_if.read_idx, idx);
        chk("busy_active", busy === 1'b1, busy, 1);
        if (respond) begin
            for (int i = 1; i < delay; i++) begin
                tick();
                chk("single_read_en", st_if.read_en === 1'b0, st_if.read_en, 0);
                chk("no_early_rsp", rsp_valid === '0, rsp_valid, 0);
            end
            tick();
            st_if.read_done  = 1'b1;
            st_if.read_valid = mem_valid[idx];
            st_if.read_m     = mem_m[idx];
            st_if.read_n     = mem_n[idx];
            st_if.read_data  = mem_data[idx];
            exp_ok   = mem_valid[idx];
            exp_m    = mem_m[idx];
            exp_n    = mem_n[idx];
            exp_data = mem_data[idx];
            exp_err  = 1'b0;
            tick();
            st_if.read_done  = 1'b0;
            st_if.read_valid = 1'($urandom);
            st_if.read_m     = DIM_W'($urandom);
            st_if.read_n     = DIM_W'($urandom);
            st_if.read_data  = rand_data();
        end else begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                tick();
                chk("no_early_timeout", err_timeout === 1'b0, err_timeout, 0);
                chk("no_rsp_before_timeout", rsp_valid === '0, rsp_valid, 0);
            end
            tick();
            exp_ok   = 1'b0;
            exp_m    = '0;
            exp_n    = '0;
            exp_data = '0;
            exp_err  = 1'b1;
        end
        chk("rsp_valid", rsp_valid === oh, rsp_valid, oh);
        chk("rsp_ok", rsp_ok === exp_ok, rsp_ok, exp_ok);
        chk("rsp_m", rsp_m === exp_m, rsp_m, exp_m);
        chk("rsp_n", rsp_n === exp_n, rsp_n, exp_n);
        chk("rsp_data", rsp_data === exp_data, rsp_data, exp_data);
        chk("err_timeout", err_timeout === exp_err, err_timeout, exp_err);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (next_req[i] && !req[i]) set_idx(i, IDX_W'($urandom_range(0, 15)));
        end
        req = next_req;
        tick();
        chk("rsp_pulse_end", rsp_valid === '0, rsp_valid, 0);
        chk("grant_cleared", grant === '0, grant, 0);
        chk("err_pulse_end", err_timeout === 1'b0, err_timeout, 0);
        chk("idle_not_busy", busy === 1'b0, busy, 0);
        chk("rsp_ok_hold", rsp_ok === exp_ok, rsp_ok, exp_ok);
        chk("rsp_data_hold", rsp_data === exp_data, rsp_data, exp_data);
    endtask

    // Hard stop in case a handshake wedges the stimulus
    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] nxt;
        int n;
        rst_n = 1'b0;
        req = '0;
        req_idx_flat = '0;
        st_if.read_done  = 1'b0;
        st_if.read_valid = 1'b0;
        st_if.read_m     = '0;
        st_if.read_n     = '0;
        st_if.read_data  = '0;
        for (int i = 0; i < 16; i++) begin
            mem_valid[i] = 1'b1;
            mem_m[i]     = DIM_W'($urandom_range(1, 5));
            mem_n[i]     = DIM_W'($urandom_range(1, 5));
            mem_data[i]  = rand_data();
        end
        mem_valid[9] = 1'b0;
        mem_m[3] = 4'd2;
        mem_n[3] = 4'd3;
        model_ptr = 0;
        exp_ok = 1'b0; exp_m = '0; exp_n = '0; exp_data = '0;

        // Reset state
        repeat (3) tick();
        chk("reset_grant", grant === '0, grant, 0);
        chk("reset_busy", busy === 1'b0, busy, 0);
        chk("reset_rsp_valid", rsp_valid === '0, rsp_valid, 0);
        chk("reset_rsp_ok", rsp_ok === 1'b0, rsp_ok, 0);
        chk("reset_rsp_data", rsp_data === '0, rsp_data, 0);
        chk("reset_read_en", st_if.read_en === 1'b0, st_if.read_en, 0);
        chk("reset_err", err_timeout === 1'b0, err_timeout, 0);
        rst_n = 1'b1;
        tick();

        // Single request to index 3, done two cycles after read_en
        set_idx(0, 4'd3);
        req = 3'b001;
        txn(2, 1'b1, 3'b000);

        // Full contention, held through four transactions
        for (int i = 0; i < NUM_REQ; i++) set_idx(i, IDX_W'($urandom_range(0, 8)));
        req = 3'b111;
        for (int t = 0; t < 4; t++) txn($urandom_range(1, 6), 1'b1, (t == 3) ? 3'b000 : 3'b111);

        // Invalid index reported by storage
        set_idx(1, 4'd9);
        req = 3'b010;
        txn(3, 1'b1, 3'b000);

        // Storage never completes; the next request is still served
        set_idx(2, 4'd4);
        req = 3'b100;
        txn(0, 1'b0, 3'b001);
        txn(2, 1'b1, 3'b000);

        // Done lands on the last permitted wait cycle
        set_idx(0, 4'd7);
        req = 3'b001;
        txn(TIMEOUT, 1'b1, 3'b000);

        // Done pulse while idle must be ignored
        tick();
        st_if.read_done  = 1'b1;
        st_if.read_valid = 1'b1;
        st_if.read_m     = 4'hF;
        st_if.read_n     = 4'hF;
        st_if.read_data  = rand_data();
        tick();
        st_if.read_done = 1'b0;
        tick();
        chk("idle_done_no_rsp", rsp_valid === '0, rsp_valid, 0);
        chk("idle_done_not_busy", busy === 1'b0, busy, 0);
        chk("idle_done_data_hold", rsp_data === exp_data, rsp_data, exp_data);
        chk("idle_done_m_hold", rsp_m === exp_m, rsp_m, exp_m);

        // Randomized traffic
        req = 3'b101;
        set_idx(0, IDX_W'($urandom_range(0, 15)));
        set_idx(2, IDX_W'($urandom_range(0, 15)));
        for (int t = 0; t < 10; t++) begin
            if (req == '0) begin
                nxt = NUM_REQ'($urandom_range(1, 7));
                for (int i = 0; i < NUM_REQ; i++) set_idx(i, IDX_W'($urandom_range(0, 15)));
                req = nxt;
            end
            nxt = NUM_REQ'($urandom_range(0, 7));
            txn($urandom_range(1, TIMEOUT), ($urandom_range(0, 4) != 0), nxt);
        end
        req = '0;
        tick();

        // Reset while waiting on storage
        set_idx(1, 4'd5);
        req = 3'b010;
        model_ptr = 0;
        n = 0;
        while (!st_if.read_en && n < 12) begin
            tick();
            n++;
        end
        chk("pre_reset_read_en", st_if.read_en === 1'b1, st_if.read_en, 1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_grant", grant === '0, grant, 0);
        chk("async_reset_busy", busy === 1'b0, busy, 0);
        chk("async_reset_rsp_ok", rsp_ok === 1'b0, rsp_ok, 0);
        chk("async_reset_rsp_data", rsp_data === '0, rsp_data, 0);
        chk("async_reset_rsp_m", rsp_m === '0, rsp_m, 0);
        model_ptr = 0;
        exp_ok = 1'b0; exp_m = '0; exp_n = '0; exp_data = '0;
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        set_idx(1, 4'd6);
        set_idx(2, 4'd8);
        req = 3'b110;
        txn(3, 1'b1, 3'b000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
